demo_scene_scheduler: RTL and testbench

//  Frame-synchronous sequencer that drives background_state and solid_color into the

---
 rtl/demo_scene_scheduler_if.sv | 35 +++
 rtl/demo_scene_scheduler.sv | 140 ++++++++++++++
 tb/tb_demo_scene_scheduler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/demo_scene_scheduler_if.sv
// demo_scene_scheduler_if
//   Groups the control inputs and scene outputs of demo_scene_scheduler.
//   slave  : the scheduler (receives vsync/controls, drives scene outputs)
//   master : the controller side (drives vsync/controls, observes scene outputs)
//   Signals:
//     vsync            frame sync from the timing generator, active-high level
//     pause            hold the current scene
//     step_btn         rising edge requests a one-scene advance
//     mode_manual      scene taken from manual_state
//     manual_state     scene requested in manual mode
//     background_state scene code to the pixel datapath (upper bits zero)
//     solid_color      {R,G,B} 2 bits each, used by scene 0
//     scene_changed    one-cycle pulse when background_state changes
//     dwell_count      frames shown in the current scene, saturating at 255
interface demo_scene_scheduler_if;
  logic       vsync;
  logic       pause;
  logic       step_btn;
  logic       mode_manual;
  logic [3:0] manual_state;
  logic [7:0] background_state;
  logic [5:0] solid_color;
  logic       scene_changed;
  logic [7:0] dwell_count;

  modport slave (
    input  vsync, pause, step_btn, mode_manual, manual_state,
    output background_state, solid_color, scene_changed, dwell_count
  );

  modport master (
    output vsync, pause, step_btn, mode_manual, manual_state,
    input  background_state, solid_color, scene_changed, dwell_count
  );
endinterface

// File: rtl/demo_scene_scheduler.sv
// demo_scene_scheduler
//   Frame-synchronous scene sequencer feeding background_state and solid_color
//   into the pixel colour datapath. Scenes advance automatically after a dwell
//   time, with pause, single-step and manual-select overrides. Every output
//   change is applied on a vsync rising edge so a scene never switches mid-frame.
//   Ports:
//     clk  pixel clock, the only clock
//     rst  synchronous reset, active-high
//     bus  demo_scene_scheduler_if.slave (controls in, scene outputs out)
module demo_scene_scheduler #(
  parameter int        NUM_SCENES   = 12,
  parameter int        DWELL_FRAMES = 256,
  parameter logic [5:0] COLOR_STEP  = 6'd5,
  parameter logic [5:0] RESET_COLOR = 6'h30
) (
  input logic                    clk,
  input logic                    rst,
  demo_scene_scheduler_if.slave  bus
);

  // Dwell counter is at least 8 bits so dwell_count can reach 255 even for
  // short dwell times (manual mode keeps counting past DWELL_FRAMES).
  localparam int CW = ($clog2(DWELL_FRAMES + 1) > 8) ? $clog2(DWELL_FRAMES + 1) : 8;
  localparam logic [7:0]    LAST_SCENE   = 8'(NUM_SCENES - 1);
  localparam logic [7:0]    NUM_SCENES_B = 8'(NUM_SCENES);
  localparam logic [CW-1:0] DWELL_LAST   = CW'(DWELL_FRAMES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSE  = 2'd1,
    MANUAL = 2'd2
  } mode_e;

  mode_e         mode_q, mode_d;
  logic          vsync_q, step_q;
  logic          step_pending_q, step_pending_d;
  logic [7:0]    bs_q, bs_d;
  logic [5:0]    color_q, color_d;
  logic          changed_q, changed_d;
  logic [CW-1:0] dwell_q, dwell_d;

  logic          frame_tick;
  logic          step_rise;
  logic [7:0]    adv_bs;
  logic [5:0]    adv_color;
  logic [7:0]    manual_sel;
  logic [CW-1:0] dwell_inc;

  // Next-state logic. Scene, colour and dwell only move on a frame tick; the
  // mode register tracks the control levels every cycle so a mid-frame mode
  // change is only acted on at the following tick.
  always_comb begin
    frame_tick = bus.vsync & ~vsync_q;
    step_rise  = bus.step_btn & ~step_q;

    if (bus.mode_manual)  mode_d = MANUAL;
    else if (bus.pause)   mode_d = PAUSE;
    else                  mode_d = RUN;

    adv_bs     = (bs_q == LAST_SCENE) ? 8'd0 : bs_q + 8'd1;
    adv_color  = (bs_q == LAST_SCENE) ? color_q + COLOR_STEP : color_q;
    manual_sel = ({4'b0, bus.manual_state} < NUM_SCENES_B) ? {4'b0, bus.manual_state} : 8'd0;
    dwell_inc  = (&dwell_q) ? dwell_q : dwell_q + CW'(1);

    bs_d           = bs_q;
    color_d        = color_q;
    dwell_d        = dwell_q;
    step_pending_d = step_pending_q;

    if (frame_tick) begin
      // A pending request is consumed by this tick; a rise in the same cycle
      // is kept for the next frame.
      step_pending_d = step_rise && (mode_q != MANUAL);
      case (mode_q)
        RUN: begin
          if (step_pending_q || dwell_q >= DWELL_LAST) begin
            bs_d    = adv_bs;
            color_d = adv_color;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_inc;
          end
        end
        PAUSE: begin
          if (step_pending_q) begin
            bs_d    = adv_bs;
            color_d = adv_color;
            dwell_d = '0;
          end
        end
        default: begin
          bs_d    = manual_sel;
          dwell_d = (manual_sel != bs_q) ? '0 : dwell_inc;
        end
      endcase
    end else if (step_rise && mode_q != MANUAL) begin
      step_pending_d = 1'b1;
    end

    changed_d = (bs_d != bs_q);
  end

  // State registers. Edge detectors reset high so a level already asserted
  // when reset releases is not mistaken for an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q         <= RUN;
      vsync_q        <= 1'b1;
      step_q         <= 1'b1;
      step_pending_q <= 1'b0;
      bs_q           <= 8'd0;
      color_q        <= RESET_COLOR;
      changed_q      <= 1'b0;
      dwell_q        <= '0;
    end else begin
      mode_q         <= mode_d;
      vsync_q        <= bus.vsync;
      step_q         <= bus.step_btn;
      step_pending_q <= step_pending_d;
      bs_q           <= bs_d;
      color_q        <= color_d;
      changed_q      <= changed_d;
      dwell_q        <= dwell_d;
    end
  end

  // Saturate the reported dwell at 255 when the counter is wider than 8 bits.
  generate
    if (CW > 8) begin : g_wide_dwell
      assign bus.dwell_count = (|dwell_q[CW-1:8]) ? 8'hFF : dwell_q[7:0];
    end else begin : g_narrow_dwell
      assign bus.dwell_count = dwell_q[7:0];
    end
  endgenerate

  assign bus.background_state = bs_q;
  assign bus.solid_color      = color_q;
  assign bus.scene_changed    = changed_q;

endmodule

// File: tb/tb_demo_scene_scheduler.sv
// tb_demo_scene_scheduler
//   Directed self-checking bench for demo_scene_scheduler with a short dwell
//   (4 frames) so auto-advance, wrap, pause, step, manual and reset behaviour
//   can all be exercised with hand-computed expectations.
module tb_demo_scene_scheduler;

  logic clk;
  logic rst;
  demo_scene_scheduler_if bus();

  int total = 0;
  int bad   = 0;
  int scCount = 0;
  int scBase;

  logic [7:0] preBs;
  logic [7:0] lastBs;
  logic       lastSc;

  demo_scene_scheduler #(
    .NUM_SCENES  (12),
    .DWELL_FRAMES(4),
    .COLOR_STEP  (6'd5),
    .RESET_COLOR (6'h30)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running pixel clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which scene_changed is seen high.
  always @(negedge clk) begin
    if (bus.scene_changed === 1'b1) scCount++;
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Produce whole frames: vsync rises, stays high 3 cycles, low 4 cycles.
  // Captures the scene just before and just after the tick edge.
  task automatic applyStimulus(input int frames);
    for (int f = 0; f < frames; f++) begin
      @(negedge clk);
      preBs = bus.background_state;
      bus.vsync = 1'b1;
      @(negedge clk);
      lastBs = bus.background_state;
      lastSc = bus.scene_changed;
      repeat (2) @(negedge clk);
      bus.vsync = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  // One step_btn press and release.
  task automatic pressStep();
    @(negedge clk);
    bus.step_btn = 1'b1;
    @(negedge clk);
    bus.step_btn = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst              = 1'b1;
    bus.vsync        = 1'b0;
    bus.pause        = 1'b0;
    bus.step_btn     = 1'b0;
    bus.mode_manual  = 1'b0;
    bus.manual_state = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("rst_bs",    bus.background_state, 0);
    checkOutput("rst_color", bus.solid_color, 6'h30);
    checkOutput("rst_sc",    bus.scene_changed, 0);
    checkOutput("rst_dwell", bus.dwell_count, 0);

    // Auto-advance every 4 frames.
    scBase = scCount;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("t1_bs%0d", k), lastBs, (k < 4) ? 0 : (k < 8) ? 1 : 2);
      if (k == 3) checkOutput("t1_dwell3", bus.dwell_count, 3);
      if (k == 4) begin
        checkOutput("t1_pre4", preBs, 0);
        checkOutput("t1_sc4",  lastSc, 1);
      end
    end
    checkOutput("t1_sccount", scCount - scBase, 2);

    // Wrap 11 -> 0 bumps the colour.
    applyStimulus(39);
    checkOutput("t2_bs47",    bus.background_state, 11);
    checkOutput("t2_color47", bus.solid_color, 6'h30);
    applyStimulus(1);
    checkOutput("t2_bs48",    lastBs, 0);
    checkOutput("t2_sc48",    lastSc, 1);
    checkOutput("t2_color48", bus.solid_color, 6'h35);
    applyStimulus(48);
    checkOutput("t2_bs96",    bus.background_state, 0);
    checkOutput("t2_color96", bus.solid_color, 6'h3A);

    // Pause freezes scene and dwell; several steps give one advance.
    applyStimulus(13);
    checkOutput("t3_bs",    bus.background_state, 3);
    checkOutput("t3_dwell", bus.dwell_count, 1);
    @(negedge clk);
    bus.pause = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(10);
    checkOutput("t3_pbs",    bus.background_state, 3);
    checkOutput("t3_pdwell", bus.dwell_count, 1);
    pressStep();
    pressStep();
    pressStep();
    checkOutput("t3_prestep", bus.background_state, 3);
    applyStimulus(1);
    checkOutput("t3_step_bs",    lastBs, 4);
    checkOutput("t3_step_dwell", bus.dwell_count, 0);
    applyStimulus(1);
    checkOutput("t3_single", bus.background_state, 4);

    // Manual select waits for the tick; out-of-range maps to 0; steps ignored.
    @(negedge clk);
    bus.mode_manual  = 1'b1;
    bus.manual_state = 4'd9;
    repeat (3) @(negedge clk);
    checkOutput("t4_hold", bus.background_state, 4);
    applyStimulus(1);
    checkOutput("t4_bs9",    lastBs, 9);
    checkOutput("t4_sc9",    lastSc, 1);
    checkOutput("t4_dwell9", bus.dwell_count, 0);
    pressStep();
    bus.manual_state = 4'd14;
    applyStimulus(1);
    checkOutput("t4_bs14", lastBs, 0);
    applyStimulus(1);
    checkOutput("t4_same_sc",    lastSc, 0);
    checkOutput("t4_same_dwell", bus.dwell_count, 1);
    @(negedge clk);
    bus.mode_manual = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(1);
    checkOutput("t4_noadv", bus.background_state, 0);
    bus.pause = 1'b0;

    // vsync high across reset release must not tick.
    @(negedge clk);
    rst       = 1'b1;
    bus.vsync = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t5_notick", bus.dwell_count, 0);
    bus.vsync = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(1);
    checkOutput("t5_tick", bus.dwell_count, 1);
    applyStimulus(27);
    checkOutput("t5_bs7", bus.background_state, 7);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_rst_bs",    bus.background_state, 0);
    checkOutput("t5_rst_color", bus.solid_color, 6'h30);
    checkOutput("t5_rst_dwell", bus.dwell_count, 0);

    // Step in RUN restarts the dwell.
    applyStimulus(1);
    checkOutput("t6_dwell1", bus.dwell_count, 1);
    pressStep();
    applyStimulus(1);
    checkOutput("t6_bs",    lastBs, 1);
    checkOutput("t6_dwell", bus.dwell_count, 0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("t6_run%0d", k), lastBs, (k < 4) ? 1 : 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
